// File: rtl/ahb_prio_arbiter.sv
// AHB layer arbiter: max priority wins, ties rotate, bursts/locks hold the bus.
// Define ARB_STARVE_EN to add per-master starvation escalation after TIMEOUT.
module ahb_prio_arbiter #(
  parameter int MASTER_NUM     = 4,
  parameter int PRIORBIT       = 2,
  parameter int DEFAULT_MASTER = 0,
  parameter int TIMEOUT        = 16
) (
  input  logic                           hclk,
  input  logic                           hreset,
  input  logic [MASTER_NUM-1:0]          hbusreq,
  input  logic [MASTER_NUM-1:0]          hlock,
  input  logic [MASTER_NUM*PRIORBIT-1:0] prio,
  input  logic [1:0]                     htrans,
  input  logic [2:0]                     hburst,
  input  logic                           hready,
  output logic [MASTER_NUM-1:0]          hgrant,
  output logic [$clog2(MASTER_NUM)-1:0]  hmaster,
  output logic                           hmastlock
);
  localparam int IW = $clog2(MASTER_NUM);
  localparam int EW = PRIORBIT + 1;
  localparam logic [IW-1:0] DEF = IW'(DEFAULT_MASTER);
  localparam logic [MASTER_NUM-1:0] DEF_OH =
    MASTER_NUM'(1) << DEFAULT_MASTER;

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BURST,
    S_LOCKED
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [3:0]            r_beat;
  logic [3:0]            w_beat_nxt;
  logic [3:0]            w_load;
  logic [MASTER_NUM-1:0] r_grant;
  logic [IW-1:0]         r_rr;
  logic [IW-1:0]         r_hmaster;
  logic                  r_mlock;

  logic [IW-1:0]         w_gidx;
  logic [IW-1:0]         w_win;
  logic [IW-1:0]         w_j;
  logic [MASTER_NUM-1:0] w_win_oh;
  logic                  w_any;
  logic [EW-1:0]         w_best;
  logic [EW-1:0]         w_eff [MASTER_NUM];
  logic [MASTER_NUM-1:0] w_starve;
  logic                  w_fixed;
  logic                  w_last;
  logic                  w_rearb;
  logic                  w_lock_win;
  logic                  w_unused;

  assign w_unused = hburst[0] ^ TIMEOUT[0];

  function automatic logic [IW-1:0] rr_idx(
    input logic [IW-1:0] base,
    input int            k
  );
    int s;
    s = (int'(base) + k) % MASTER_NUM;
    return IW'(s);
  endfunction

`ifdef ARB_STARVE_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_wait [MASTER_NUM];

  always_ff @(posedge hclk) begin
    if (hreset) begin
      for (int i = 0; i < MASTER_NUM; i++)
        r_wait[i] <= '0;
    end else begin
      for (int i = 0; i < MASTER_NUM; i++) begin
        if (!hbusreq[i] || r_grant[i])
          r_wait[i] <= '0;
        else if (r_wait[i] != CW'(TIMEOUT))
          r_wait[i] <= r_wait[i] + 1'b1;
      end
    end
  end

  always_comb begin
    w_starve = '0;
    for (int i = 0; i < MASTER_NUM; i++)
      w_starve[i] = (r_wait[i] == CW'(TIMEOUT));
  end
`else
  assign w_starve = '0;
`endif

  // Starving masters outrank every programmable priority
  always_comb begin
    for (int i = 0; i < MASTER_NUM; i++)
      w_eff[i] = {w_starve[i], prio[i*PRIORBIT +: PRIORBIT]};
  end

  always_comb begin
    w_any    = 1'b0;
    w_win    = DEF;
    w_best   = '0;
    w_j      = '0;
    w_win_oh = '0;
    for (int k = 1; k <= MASTER_NUM; k++) begin
      w_j = rr_idx(r_rr, k);
      if (hbusreq[w_j] && (!w_any || w_eff[w_j] > w_best)) begin
        w_any  = 1'b1;
        w_win  = w_j;
        w_best = w_eff[w_j];
      end
    end
    w_win_oh[w_win] = 1'b1;
  end

  always_comb begin
    w_gidx = '0;
    for (int i = 0; i < MASTER_NUM; i++)
      if (r_grant[i]) w_gidx = IW'(i);
  end

  always_comb begin
    w_load = 4'd0;
    unique case (hburst[2:1])
      2'b01:   w_load = 4'd3;
      2'b10:   w_load = 4'd7;
      2'b11:   w_load = 4'd15;
      default: w_load = 4'd0;
    endcase
  end

  assign w_fixed = (htrans == T_NONSEQ) && (hburst[2:1] != 2'b00);
  assign w_last  = (r_state == S_BURST) && (htrans == T_SEQ) &&
                   (r_beat == 4'd1);
  // The NONSEQ opening a fixed burst must not hand the bus away
  assign w_rearb = hready &&
                   (((r_state == S_IDLE) && !w_fixed) || w_last);
  assign w_lock_win = w_any && hlock[w_win];

  always_comb begin
    w_beat_nxt = r_beat;
    if (w_fixed)
      w_beat_nxt = w_load;
    else if ((htrans == T_SEQ) && (r_beat != 4'd0))
      w_beat_nxt = r_beat - 4'd1;
    else if (htrans == T_IDLE)
      w_beat_nxt = 4'd0;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_rearb && w_lock_win)
          w_state_nxt = S_LOCKED;
        else if (w_fixed)
          w_state_nxt = S_BURST;
      end
      S_BURST: begin
        if (w_rearb)
          w_state_nxt = w_lock_win ? S_LOCKED : S_IDLE;
        else if (htrans == T_IDLE)
          w_state_nxt = S_IDLE;
      end
      S_LOCKED: begin
        if (!hlock[w_gidx])
          w_state_nxt = (w_beat_nxt != 4'd0) ? S_BURST : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_state   <= S_IDLE;
      r_beat    <= 4'd0;
      r_grant   <= DEF_OH;
      r_rr      <= DEF;
      r_hmaster <= DEF;
      r_mlock   <= 1'b0;
    end else if (hready) begin
      r_state   <= w_state_nxt;
      r_beat    <= w_beat_nxt;
      r_hmaster <= w_gidx;
      r_mlock   <= hlock[w_gidx];
      if (w_rearb) begin
        r_grant <= w_any ? w_win_oh : DEF_OH;
        if (w_any) r_rr <= w_win;
      end
    end
  end

  assign hgrant    = r_grant;
  assign hmaster   = r_hmaster;
  assign hmastlock = r_mlock;

endmodule

// File: tb/tb_ahb_prio_arbiter.sv
// Directed bench for ahb_prio_arbiter: vector table plus burst/lock/starve runs.
module tb_ahb_prio_arbiter;
  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;

  logic       hclk = 1'b0;
  logic       hreset;
  logic [3:0] hbusreq;
  logic [3:0] hlock;
  logic [7:0] prio;
  logic [1:0] htrans;
  logic [2:0] hburst;
  logic       hready;
  logic [3:0] hgrant;
  logic [1:0] hmaster;
  logic       hmastlock;

  int checks = 0;
  int errors = 0;

  ahb_prio_arbiter dut (
    .hclk      (hclk),
    .hreset    (hreset),
    .hbusreq   (hbusreq),
    .hlock     (hlock),
    .prio      (prio),
    .htrans    (htrans),
    .hburst    (hburst),
    .hready    (hready),
    .hgrant    (hgrant),
    .hmaster   (hmaster),
    .hmastlock (hmastlock)
  );

  always #5 hclk = ~hclk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] lck;
    logic [7:0] pr;
    logic [1:0] tr;
    logic [2:0] hb;
    logic       rdy;
    logic [3:0] eg;
    logic [1:0] em;
    logic       eml;
  } vec_t;

  vec_t vt [15];

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    hreset  = 1'b1;
    hbusreq = 4'b0000;
    hlock   = 4'b0000;
    prio    = 8'h00;
    htrans  = T_IDLE;
    hburst  = 3'b000;
    hready  = 1'b1;
    tick();
    tick();
    hreset  = 1'b0;
  endtask

  task automatic burst8(input int stall_at, input int stall_len,
                        input string tag);
    do_reset();
    hbusreq = 4'b0010;
    tick();
    chk({tag, "_grant_m1"}, 32'(hgrant), 32'(4'b0010));
    tick();
    chk({tag, "_owner_m1"}, 32'(hmaster), 32'd1);
    htrans = T_NONSEQ;
    hburst = 3'b101;
    tick();
    chk({tag, "_beat1"}, 32'(hgrant), 32'(4'b0010));
    hbusreq = 4'b0100;
    prio    = 8'h30;
    htrans  = T_SEQ;
    for (int b = 2; b <= 8; b++) begin
      if (b == stall_at) begin
        hready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          tick();
          chk({tag, "_stall"}, 32'(hgrant), 32'(4'b0010));
        end
        hready = 1'b1;
      end
      tick();
      chk($sformatf("%s_beat%0d", tag, b), 32'(hgrant),
          (b == 8) ? 32'(4'b0100) : 32'(4'b0010));
    end
    chk({tag, "_owner_end"}, 32'(hmaster), 32'd1);
    htrans = T_IDLE;
    tick();
    chk({tag, "_owner_m2"}, 32'(hmaster), 32'd2);
    chk({tag, "_grant_m2"}, 32'(hgrant), 32'(4'b0100));
  endtask

  initial begin
    int first;
    vt[0]  = '{1'b0, 4'b1010, 4'b0, 8'hC4, T_IDLE,   3'b000, 1'b1, 4'b1000, 2'd0, 1'b0};
    vt[1]  = '{1'b0, 4'b1010, 4'b0, 8'hC4, T_IDLE,   3'b000, 1'b1, 4'b1000, 2'd3, 1'b0};
    vt[2]  = '{1'b0, 4'b1111, 4'b0, 8'hAA, T_IDLE,   3'b000, 1'b0, 4'b1000, 2'd3, 1'b0};
    vt[3]  = '{1'b1, 4'b0000, 4'b0, 8'h00, T_IDLE,   3'b000, 1'b1, 4'b0001, 2'd0, 1'b0};
    vt[4]  = '{1'b0, 4'b1111, 4'b0, 8'hAA, T_NONSEQ, 3'b000, 1'b1, 4'b0010, 2'd0, 1'b0};
    vt[5]  = '{1'b0, 4'b1111, 4'b0, 8'hAA, T_NONSEQ, 3'b000, 1'b1, 4'b0100, 2'd1, 1'b0};
    vt[6]  = '{1'b0, 4'b1111, 4'b0, 8'hAA, T_NONSEQ, 3'b000, 1'b1, 4'b1000, 2'd2, 1'b0};
    vt[7]  = '{1'b0, 4'b1111, 4'b0, 8'hAA, T_NONSEQ, 3'b000, 1'b1, 4'b0001, 2'd3, 1'b0};
    vt[8]  = '{1'b0, 4'b1111, 4'b0, 8'hAA, T_NONSEQ, 3'b000, 1'b1, 4'b0010, 2'd0, 1'b0};
    vt[9]  = '{1'b0, 4'b1111, 4'b0, 8'hAA, T_NONSEQ, 3'b000, 1'b0, 4'b0010, 2'd0, 1'b0};
    vt[10] = '{1'b0, 4'b1111, 4'b0, 8'hAB, T_NONSEQ, 3'b000, 1'b1, 4'b0001, 2'd1, 1'b0};
    vt[11] = '{1'b0, 4'b0000, 4'b0, 8'hAA, T_IDLE,   3'b000, 1'b1, 4'b0001, 2'd0, 1'b0};
    vt[12] = '{1'b0, 4'b0110, 4'b0, 8'hAA, T_NONSEQ, 3'b000, 1'b1, 4'b0010, 2'd0, 1'b0};
    vt[13] = '{1'b0, 4'b0110, 4'b0, 8'hAA, T_NONSEQ, 3'b000, 1'b1, 4'b0100, 2'd1, 1'b0};
    vt[14] = '{1'b0, 4'b0110, 4'b0, 8'hAE, T_NONSEQ, 3'b000, 1'b1, 4'b0010, 2'd2, 1'b0};

    do_reset();
    chk("rst_grant", 32'(hgrant), 32'(4'b0001));
    chk("rst_master", 32'(hmaster), 32'd0);
    chk("rst_mlock", 32'(hmastlock), 32'd0);

    for (int c = 0; c < 20; c++) begin
      tick();
      chk("park_grant", 32'(hgrant), 32'(4'b0001));
      chk("park_master", 32'(hmaster), 32'd0);
    end

    for (int i = 0; i < 15; i++) begin
      hreset  = vt[i].rst;
      hbusreq = vt[i].req;
      hlock   = vt[i].lck;
      prio    = vt[i].pr;
      htrans  = vt[i].tr;
      hburst  = vt[i].hb;
      hready  = vt[i].rdy;
      tick();
      chk($sformatf("vec%0d_grant", i), 32'(hgrant), 32'(vt[i].eg));
      chk($sformatf("vec%0d_master", i), 32'(hmaster), 32'(vt[i].em));
      chk($sformatf("vec%0d_mlock", i), 32'(hmastlock), 32'(vt[i].eml));
    end
    hreset = 1'b0;

    burst8(0, 0, "burst");
    burst8(4, 3, "burst_stall");

    do_reset();
    hbusreq = 4'b0001;
    hlock   = 4'b0001;
    tick();
    chk("lock_grant", 32'(hgrant), 32'(4'b0001));
    chk("lock_mlock_on", 32'(hmastlock), 32'd1);
    hbusreq = 4'b1001;
    prio    = 8'hC0;
    htrans  = T_NONSEQ;
    for (int t = 0; t < 3; t++) begin
      tick();
      chk("lock_hold_grant", 32'(hgrant), 32'(4'b0001));
      chk("lock_hold_mlock", 32'(hmastlock), 32'd1);
    end
    hlock   = 4'b0000;
    hbusreq = 4'b1000;
    htrans  = T_IDLE;
    tick();
    chk("lock_release_grant", 32'(hgrant), 32'(4'b0001));
    chk("lock_release_mlock", 32'(hmastlock), 32'd0);
    tick();
    chk("lock_m3_grant", 32'(hgrant), 32'(4'b1000));
    tick();
    chk("lock_m3_master", 32'(hmaster), 32'd3);

    do_reset();
    hbusreq = 4'b1100;
    prio    = 8'hC0;
    first   = 0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (n == 1)
        chk("starve_m3_first", 32'(hgrant), 32'(4'b1000));
      if (first == 0 && hgrant[2])
        first = n;
    end
`ifdef ARB_STARVE_EN
    chk("starve_m2_edge", 32'(first), 32'd17);
`else
    chk("no_starve_m2", 32'(first), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
